// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider (N >= 2) with tick strobe
// Optional 50% duty for odd ratios: define CLK_DIV_ODD_DUTY50_EN.
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic             cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             load_bad;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] high_len;
  logic             wrap;

  assign load_bad = div_val < CNT_W'(2);
  assign load_val = load_bad ? CNT_W'(2) : div_val;
  assign last_cnt = ratio_q - CNT_W'(1);
  assign wrap     = (cnt_q == last_cnt);

`ifdef CLK_DIV_ODD_DUTY50_EN
  // Posedge term covers floor(N/2) cycles; the negedge flop adds the half cycle for odd N.
  assign high_len = ratio_q >> 1;
`else
  // ceil(N/2) built without forming N+1, so N = 2^CNT_W-1 cannot overflow.
  assign high_len = (ratio_q >> 1) + {{(CNT_W-1){1'b0}}, ratio_q[0]};
`endif

  always_comb begin
    state_d    = en ? RUN : IDLE;
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    clk_d      = 1'b0;
    tick_d     = 1'b0;
    err_d      = div_load ? load_bad : err_q;

    if (state_d == RUN) begin
      clk_d  = (cnt_q < high_len);
      tick_d = (cnt_q == '0);
      cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
      if (wrap) begin
        if (div_load) begin
          ratio_d = load_val;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          ratio_d = pend_val_q;
          pend_d  = 1'b0;
        end
      end else if (div_load) begin
        pend_val_d = load_val;
        pend_d     = 1'b1;
      end
    end else begin
      cnt_d = '0;
      // Dropping en ends the period, so a waiting ratio takes effect here.
      if (state_q == RUN && pend_q) begin
        ratio_d = pend_val_q;
        pend_d  = 1'b0;
      end
      if (div_load) begin
        ratio_d = load_val;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ratio_q    <= CNT_W'(DIV_DEFAULT);
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic odd_q;
  logic neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      odd_q <= 1'b0;
    end else begin
      odd_q <= (state_d == RUN) & ratio_q[0];
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= (state_q == RUN) ? (clk_q & odd_q) : 1'b0;
    end
  end

  assign clk_out = clk_q | neg_q;
`else
  assign clk_out = clk_q;
`endif

  assign tick    = tick_q;
  assign pending = pend_q;
  assign cfg_err = err_q;

endmodule
